mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one unified single-port instruction/data memory between the fetch stage (IF) and the data-access stage (MEM) of the 5-stage RV32I pipeline. It arbitrates one transaction at a time onto a req/ack memory bus and returns read data with a one-cycle-registered valid pulse. Data accesses have priority, and a bounded starvation counter protects fetch. The block sits between the pipeline's `ins_address`/`instruction_i` and `RAM_*`/`MEM_result_i` ports and the external memory.

## Interface
- `size`, 32 — address/data width.
- `STARVE_MAX`, 4 — number of consecutive data grants, made while fetch is waiting, after which fetch wins the next contested arbitration. Range 1–15.

- `clk` in 1 — the single clock.
- `reset` in 1 — reset is synchronous and active-low.
- `if_req` in 1 — fetch request. Held with `if_addr` until `if_gnt`.
- `if_addr` in size — fetch address.
- `if_kill` in 1 — mispredict flush: discard the outstanding or pending fetch.
- `if_gnt` out 1 — combinational. The fetch request is accepted this cycle.
- `if_rvalid` out 1 — one-cycle pulse: `if_rdata` is valid.
- `if_rdata` out size — fetched instruction (registered).
- `d_req` in 1 — data request. Held with the `d_*` fields until `d_gnt`.
- `d_we` in 1 — 1 = write, 0 = read.
- `d_ctrl` in 3 — size/sign code. Passed unchanged to `mem_ctrl`.
- `d_addr` in size — data address.
- `d_wdata` in size — write data.
- `d_gnt` out 1 — combinational. The data request is accepted this cycle.
- `d_rvalid` out 1 — one-cycle pulse: the data transaction is complete (reads and writes).
- `d_rdata` out size — load data (registered). Updated only by reads.
- `mem_req` out 1 — memory request. Held until `mem_ack`.
- `mem_we` out 1 — memory write enable.
- `mem_ctrl` out 3 — size code. Always 3'b010 for fetches.
- `mem_addr` out size — memory address.
- `mem_wdata` out size — memory write data.
- `mem_ack` in 1 — memory completion. `mem_rdata` is valid in this cycle.
- `mem_rdata` in size — memory read data.

## Operation
- **FSM states:** IDLE, BUSY.
- **Reset** (`reset`=0 at a rising edge):
  - State goes to IDLE; the owner flag is cleared.
  - `mem_req`, `mem_we`, `if_rvalid`, `d_rvalid` = 0.
  - `mem_addr`, `mem_wdata`, `if_rdata`, `d_rdata` = 0; `mem_ctrl` = 0.
  - Starvation counter and kill flag = 0.
- **IDLE — arbitration.** Effective fetch request: `fr` = `if_req & ~if_kill`.
  - Data wins when `d_req` is high and (`fr` is low or the counter < `STARVE_MAX`).
  - Otherwise fetch wins if `fr` is high.
  - The winner's `*_gnt` is 1 for that cycle only, and `gnt` is only ever asserted in IDLE.
  - At the edge: latch the winner's fields into the `mem_*` registers, set `mem_req`=1, record the owner, and go to BUSY.
- **Starvation counter:**
  - +1 (saturating at `STARVE_MAX`) on each data grant while `fr`=1.
  - Cleared on any fetch grant, and in any cycle where `fr`=0.
- **BUSY:**
  - `mem_req` and all `mem_*` fields stay stable until `mem_ack`.
  - On `mem_ack`: `mem_req`→0 and state→IDLE at that edge.
  - The owner's `*_rvalid`→1 for exactly the next cycle.
  - Read data is captured into `if_rdata` (fetch owner) or `d_rdata` (data read). `d_rdata` is unchanged on writes.
- **Kill:**
  - `if_kill` while the owner is fetch (BUSY) sets the kill flag.
  - The memory transaction still completes, but `if_rvalid` is suppressed and `if_rdata` is not updated; the flag clears on `mem_ack`.
  - `if_kill` in IDLE masks `if_req` in that cycle, so no fetch grant is issued.
  - `if_kill` has no effect on data transactions.
- **Simultaneous events:**
  - `mem_ack` in the same cycle as `if_kill` (fetch owner): the response is suppressed.
  - A new arbitration may occur in the cycle `*_rvalid` is high, since the state is IDLE.
- **Reset mid-BUSY:** the transaction is abandoned with no `rvalid`. The memory must tolerate an abandoned request (`mem_req` dropping before ack).

## Timing
- **Minimum latency:** grant at cycle N; `mem_req` high in N+1; `mem_ack` in N+1; `rvalid` in N+2.
- **Back-to-back throughput:** one transaction per 2 cycles with zero-wait memory.
- **Wait states:** each extra cycle without `mem_ack` adds one cycle of latency. There is no timeout.
- **Registered vs combinational:** all outputs are registered except `if_gnt` and `d_gnt`, which depend combinationally on state, `if_req`, `if_kill`, `d_req` and the counter.
- **Pipeline stall:** the pipeline stalls the requesting stage while `req`=1 and `gnt`=0, and while waiting for `rvalid`.

## Test plan
- **Reset:**
  - Stimulus: hold `reset`=0 for 2 cycles with `d_req`=`if_req`=1.
  - Required: no `gnt`, all outputs 0.
  - Stimulus: release `reset`.
  - Required: `d_gnt`=1 in the first cycle after release.
- **Single read, zero wait:**
  - Stimulus: `if_req`, `if_addr`=0x100, ack immediately with `mem_rdata`=0x00000013.
  - Required: `if_gnt` at N, `mem_req`/`mem_addr`=0x100 at N+1, `if_rvalid`=1 with `if_rdata`=0x00000013 at N+2.
- **Data write with 3 wait cycles:**
  - Stimulus: `d_we`=1, `d_addr`=0x2000, `d_wdata`=0xDEADBEEF, `d_ctrl`=3'b010.
  - Required: `mem_*` fields stable for 4 cycles; `d_rvalid` one cycle after ack; `d_rdata` unchanged.
- **Starvation, `STARVE_MAX`=4:**
  - Stimulus: `if_req` and `d_req` held high continuously, zero-wait memory.
  - Required: grant order is D,D,D,D,F,D,D,D,D,F.
- **Kill:**
  - Stimulus: fetch granted, `if_kill` pulsed in BUSY before a delayed ack.
  - Required: `mem_ack` is consumed, `if_rvalid` stays 0, `if_rdata` holds its old value, and the next request is granted normally.
- **Reset mid-BUSY:**
  - Stimulus: assert `reset` while `mem_req`=1.
  - Required: `mem_req`=0 at the next edge, no `rvalid`, state IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the pipeline fetch (IF) and data (MEM) ports onto one req/ack memory bus.
// Data wins contested arbitration unless fetch has been starved for STARVE_MAX data grants.
module mem_port_arbiter #(
    parameter int unsigned size       = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [size-1:0] if_addr,
    input  logic            if_kill,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [size-1:0] if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [2:0]      d_ctrl,
    input  logic [size-1:0] d_addr,
    input  logic [size-1:0] d_wdata,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [size-1:0] d_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [2:0]      mem_ctrl,
    output logic [size-1:0] mem_addr,
    output logic [size-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [size-1:0] mem_rdata
);

    localparam int unsigned CW         = 4;
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);
    localparam logic [2:0]  CTRL_WORD  = 3'b010;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            r_state,     w_state_nxt;
    logic              r_owner_d,   w_owner_d_nxt;
    logic              r_kill,      w_kill_nxt;
    logic [CW-1:0]     r_cnt,       w_cnt_nxt;
    logic              r_mem_req,   w_mem_req_nxt;
    logic              r_mem_we,    w_mem_we_nxt;
    logic [2:0]        r_mem_ctrl,  w_mem_ctrl_nxt;
    logic [size-1:0]   r_mem_addr,  w_mem_addr_nxt;
    logic [size-1:0]   r_mem_wdata, w_mem_wdata_nxt;
    logic              r_if_rvalid, w_if_rvalid_nxt;
    logic [size-1:0]   r_if_rdata,  w_if_rdata_nxt;
    logic              r_d_rvalid,  w_d_rvalid_nxt;
    logic [size-1:0]   r_d_rdata,   w_d_rdata_nxt;

    logic w_fr;
    logic w_d_win;
    logic w_f_win;

    // Arbitration; grants are held off while reset is asserted.
    always_comb begin
        w_fr    = if_req & ~if_kill;
        w_d_win = reset & (r_state == IDLE) & d_req & (~w_fr | (r_cnt < STARVE_LIM));
        w_f_win = reset & (r_state == IDLE) & w_fr & ~w_d_win;
    end

    assign if_gnt = w_f_win;
    assign d_gnt  = w_d_win;

    always_comb begin
        w_state_nxt     = r_state;
        w_owner_d_nxt   = r_owner_d;
        w_kill_nxt      = r_kill;
        w_cnt_nxt       = r_cnt;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_ctrl_nxt  = r_mem_ctrl;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_if_rvalid_nxt = 1'b0;
        w_if_rdata_nxt  = r_if_rdata;
        w_d_rvalid_nxt  = 1'b0;
        w_d_rdata_nxt   = r_d_rdata;

        unique case (r_state)
            IDLE: begin
                if (w_d_win) begin
                    w_state_nxt     = BUSY;
                    w_owner_d_nxt   = 1'b1;
                    w_kill_nxt      = 1'b0;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = d_we;
                    w_mem_ctrl_nxt  = d_ctrl;
                    w_mem_addr_nxt  = d_addr;
                    w_mem_wdata_nxt = d_wdata;
                end else if (w_f_win) begin
                    w_state_nxt     = BUSY;
                    w_owner_d_nxt   = 1'b0;
                    w_kill_nxt      = 1'b0;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = 1'b0;
                    w_mem_ctrl_nxt  = CTRL_WORD;
                    w_mem_addr_nxt  = if_addr;
                    w_mem_wdata_nxt = '0;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    w_state_nxt   = IDLE;
                    w_mem_req_nxt = 1'b0;
                    w_kill_nxt    = 1'b0;
                    if (r_owner_d) begin
                        w_d_rvalid_nxt = 1'b1;
                        if (!r_mem_we) begin
                            w_d_rdata_nxt = mem_rdata;
                        end
                    end else if (!(r_kill | if_kill)) begin
                        w_if_rvalid_nxt = 1'b1;
                        w_if_rdata_nxt  = mem_rdata;
                    end
                end else if (!r_owner_d && if_kill) begin
                    w_kill_nxt = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // Starvation counter counts data grants made while fetch is waiting.
        if (!w_fr || w_f_win) begin
            w_cnt_nxt = '0;
        end else if (w_d_win && (r_cnt < STARVE_LIM)) begin
            w_cnt_nxt = r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_owner_d   <= 1'b0;
            r_kill      <= 1'b0;
            r_cnt       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_ctrl  <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rvalid  <= 1'b0;
            r_d_rdata   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner_d   <= w_owner_d_nxt;
            r_kill      <= w_kill_nxt;
            r_cnt       <= w_cnt_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_ctrl  <= w_mem_ctrl_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_if_rvalid <= w_if_rvalid_nxt;
            r_if_rdata  <= w_if_rdata_nxt;
            r_d_rvalid  <= w_d_rvalid_nxt;
            r_d_rdata   <= w_d_rdata_nxt;
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_ctrl  = r_mem_ctrl;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_rvalid = r_if_rvalid;
    assign if_rdata  = r_if_rdata;
    assign d_rvalid  = r_d_rvalid;
    assign d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, response scoreboard and
// hand-written sequences for starvation, kill and reset corner cases.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_kill;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [2:0]  d_ctrl;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [2:0]  mem_ctrl;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    mem_port_arbiter #(.size(32), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_ctrl(d_ctrl), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_ctrl(mem_ctrl), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fetch;
        logic        we;
        logic [31:0] data;
    } resp_t;

    typedef struct {
        logic        ifr;
        logic [31:0] ia;
        logic        dr;
        logic        dwe;
        logic [2:0]  dc;
        logic [31:0] da;
        logic [31:0] dw;
        int          wt;
        logic        exp_f;
    } vec_t;

    resp_t       sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          mem_wait = 0;
    int          wcnt = 0;
    logic        s_if_gnt = 1'b0;
    logic        s_d_gnt  = 1'b0;
    logic        prev_pend = 1'b0;
    logic [67:0] held = '0;
    logic [31:0] exp_ifr = '0;
    logic [31:0] exp_dr  = '0;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h100) return 32'h0000_0013;
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // One clock: sample at the falling edge (scoreboard, memory model), return 1ns after rise.
    task automatic tick();
        resp_t e;
        @(negedge clk);
        s_if_gnt = if_gnt;
        s_d_gnt  = d_gnt;
        if (mem_req && prev_pend)
            check("mem_stable", 96'({mem_we, mem_ctrl, mem_addr, mem_wdata}), 96'(held));
        held = {mem_we, mem_ctrl, mem_addr, mem_wdata};
        if (if_rvalid || d_rvalid) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rvalid: got if_rvalid=%b d_rvalid=%b, expected none",
                         if_rvalid, d_rvalid);
            end else begin
                e = sb_q.pop_front();
                check("rvalid_owner", 96'({if_rvalid, d_rvalid}), 96'(e.fetch ? 2'b10 : 2'b01));
                if (e.fetch) begin
                    check("if_rdata", 96'(if_rdata), 96'(e.data));
                    exp_ifr = e.data;
                end else if (e.we) begin
                    check("d_rdata_hold", 96'(d_rdata), 96'(exp_dr));
                end else begin
                    check("d_rdata", 96'(d_rdata), 96'(e.data));
                    exp_dr = e.data;
                end
            end
        end
        if (if_gnt) begin
            e.fetch = 1'b1; e.we = 1'b0; e.data = mem_fn(if_addr);
            sb_q.push_back(e);
        end
        if (d_gnt) begin
            e.fetch = 1'b0; e.we = d_we; e.data = mem_fn(d_addr);
            sb_q.push_back(e);
        end
        if (mem_req) begin
            if (wcnt >= mem_wait) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_fn(mem_addr);
            end else begin
                mem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            mem_ack = 1'b0;
            wcnt    = 0;
        end
        prev_pend = mem_req && !mem_ack;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt();
        s_if_gnt = 1'b0;
        s_d_gnt  = 1'b0;
        for (int k = 0; k < 10 && !(s_if_gnt || s_d_gnt); k++) tick();
    endtask

    task automatic drain(input string nm);
        for (int k = 0; k < 40 && sb_q.size() > 0; k++) tick();
        check(nm, 96'(sb_q.size()), 96'(0));
    endtask

    // One arbitrated transaction from IDLE: winner, latched bus fields, latency.
    task automatic do_txn(input vec_t v);
        int lat;
        if_req = v.ifr; if_addr = v.ia;
        d_req = v.dr; d_we = v.dwe; d_ctrl = v.dc; d_addr = v.da; d_wdata = v.dw;
        mem_wait = v.wt;
        wait_gnt();
        check("winner", 96'({s_if_gnt, s_d_gnt}), 96'(v.exp_f ? 2'b10 : 2'b01));
        if_req = 1'b0;
        d_req  = 1'b0;
        check("mem_req", 96'(mem_req), 96'(1));
        check("mem_addr", 96'(mem_addr), 96'(v.exp_f ? v.ia : v.da));
        check("mem_we_ctrl", 96'({mem_we, mem_ctrl}),
              96'(v.exp_f ? {1'b0, 3'b010} : {v.dwe, v.dc}));
        if (!v.exp_f && v.dwe) check("mem_wdata", 96'(mem_wdata), 96'(v.dw));
        lat = 0;
        while (sb_q.size() > 0 && lat < 40) begin
            tick();
            lat++;
        end
        check("latency", 96'(lat), 96'(v.wt + 2));
    endtask

    vec_t vecs[7];
    logic got[10];
    logic exp_order[10];
    int   n_g;

    initial begin
        vecs[0] = '{1'b1, 32'h100, 1'b0, 1'b0, 3'b010, 32'h0,    32'h0,        0, 1'b1};
        vecs[1] = '{1'b0, 32'h0,   1'b1, 1'b1, 3'b010, 32'h2000, 32'hDEADBEEF, 3, 1'b0};
        vecs[2] = '{1'b0, 32'h0,   1'b1, 1'b0, 3'b010, 32'h2000, 32'h0,        0, 1'b0};
        vecs[3] = '{1'b1, 32'h108, 1'b1, 1'b0, 3'b100, 32'h3004, 32'h0,        1, 1'b0};
        vecs[4] = '{1'b1, 32'h104, 1'b0, 1'b0, 3'b010, 32'h0,    32'h0,        2, 1'b1};
        vecs[5] = '{1'b0, 32'h0,   1'b1, 1'b1, 3'b000, 32'h11,   32'h55,       0, 1'b0};
        vecs[6] = '{1'b0, 32'h0,   1'b1, 1'b0, 3'b101, 32'hFFFC, 32'h0,        0, 1'b0};
        exp_order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        reset = 1'b0; if_req = 1'b1; if_addr = 32'h80; if_kill = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_ctrl = 3'b010; d_addr = 32'h40; d_wdata = 32'h0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        @(posedge clk);
        #1;

        // Reset held with both requests pending
        for (int i = 0; i < 2; i++) begin
            check("reset_outputs", 96'({mem_req, mem_we, mem_ctrl, mem_addr, mem_wdata,
                  if_rvalid, d_rvalid, if_rdata, d_rdata}), 96'(0));
            tick();
            check("reset_no_gnt", 96'({s_if_gnt, s_d_gnt}), 96'(0));
        end
        reset = 1'b1;
        tick();
        check("release_gnt", 96'({s_if_gnt, s_d_gnt}), 96'(2'b01));
        if_req = 1'b0;
        d_req  = 1'b0;
        drain("reset_drain");

        foreach (vecs[i]) do_txn(vecs[i]);

        // Starvation: both requests held, zero-wait memory
        tick();
        if_req = 1'b1; if_addr = 32'h300;
        d_req = 1'b1; d_we = 1'b0; d_ctrl = 3'b010; d_addr = 32'h400;
        mem_wait = 0;
        n_g = 0;
        for (int k = 0; k < 60 && n_g < 10; k++) begin
            tick();
            if (s_if_gnt) begin got[n_g] = 1'b1; n_g++; end
            else if (s_d_gnt) begin got[n_g] = 1'b0; n_g++; end
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        check("starve_grants", 96'(n_g), 96'(10));
        for (int i = 0; i < 10; i++) check($sformatf("starve_order%0d", i), 96'(got[i]), 96'(exp_order[i]));
        drain("starve_drain");

        // Kill in IDLE masks the fetch request
        if_req = 1'b1; if_addr = 32'h500; if_kill = 1'b1;
        tick();
        check("kill_idle_no_gnt", 96'(s_if_gnt), 96'(0));
        if_kill = 1'b0;
        tick();
        check("after_kill_gnt", 96'(s_if_gnt), 96'(1));
        if_req = 1'b0;
        drain("kill_idle_drain");

        // Kill in BUSY before a delayed ack
        if_req = 1'b1; if_addr = 32'h600; mem_wait = 3;
        wait_gnt();
        if_req = 1'b0;
        check("kill_busy_req", 96'(mem_req), 96'(1));
        if_kill = 1'b1;
        void'(sb_q.pop_back());
        tick();
        if_kill = 1'b0;
        for (int k = 0; k < 10 && mem_req; k++) tick();
        check("kill_ack_consumed", 96'(mem_req), 96'(0));
        tick();
        tick();
        check("kill_if_rdata", 96'(if_rdata), 96'(exp_ifr));
        do_txn(vecs[4]);

        // Kill in the same cycle as the ack
        if_req = 1'b1; if_addr = 32'h700; mem_wait = 0;
        wait_gnt();
        if_req = 1'b0;
        if_kill = 1'b1;
        void'(sb_q.pop_back());
        tick();
        if_kill = 1'b0;
        tick();
        tick();
        check("kill_ack_if_rdata", 96'(if_rdata), 96'(exp_ifr));
        check("kill_ack_idle", 96'(mem_req), 96'(0));

        // Reset in the middle of a transaction
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h800; mem_wait = 5;
        wait_gnt();
        d_req = 1'b0;
        check("rst_busy_req", 96'(mem_req), 96'(1));
        tick();
        reset = 1'b0;
        tick();
        void'(sb_q.pop_back());
        exp_dr  = '0;
        exp_ifr = '0;
        check("rst_busy_mem_req", 96'(mem_req), 96'(0));
        check("rst_busy_rvalid", 96'({if_rvalid, d_rvalid}), 96'(0));
        reset = 1'b1;
        d_req = 1'b1; mem_wait = 0;
        tick();
        check("rst_busy_idle_gnt", 96'(s_d_gnt), 96'(1));
        d_req = 1'b0;
        drain("rst_busy_drain");
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
